// File: rtl/esp_tx_arbiter.sv
// esp_tx_arbiter: shares the ESP32 UART TX FIFO port between the CPU byte path and an
// auxiliary packet source, with aux packets locked atomically and a stall timeout.
module esp_tx_arbiter #(
  parameter int GAP_CYCLES   = 2,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_wr,
  input  logic [8:0] cpu_data,
  output logic       cpu_busy,
  output logic       cpu_overrun,
  input  logic       aux_valid,
  input  logic [8:0] aux_data,
  input  logic       aux_last,
  output logic       aux_ready,
  output logic       aux_abort,
  input  logic       status_clr,
  output logic       locked,
  output logic [8:0] esp_tx_data,
  output logic       esp_tx_wr,
  input  logic       esp_tx_fifo_full
);
  logic       cpu_busy_q, cpu_busy_d, cpu_gnt_q;
  logic [8:0] cpu_data_q, cpu_data_d;
  logic       overrun_q, overrun_d, abort_q, abort_d;
  logic       locked_q, locked_d, rr_q, rr_d;
  logic [3:0] gap_q, gap_d;
  logic [9:0] to_q, to_d;
  logic       wr_q, wr_d;
  logic [8:0] data_q, data_d;
  logic       can_issue, cpu_pend, gnt_aux, gnt_cpu, timeout;

  // cpu_busy stays up through the pulse cycle; cpu_gnt_q masks the byte from a second grant
  assign can_issue = !esp_tx_fifo_full && gap_q == 4'd0;
  assign cpu_pend  = cpu_busy_q && !cpu_gnt_q;
  assign gnt_aux   = can_issue && aux_valid && (locked_q || !cpu_pend || !rr_q);
  assign gnt_cpu   = can_issue && cpu_pend && !locked_q && !(aux_valid && !rr_q);
  assign timeout   = locked_q && !aux_valid && (to_q + 10'd1 == 10'(LOCK_TIMEOUT));

  assign aux_ready   = gnt_aux && reset_n;
  assign cpu_busy    = cpu_busy_q;
  assign cpu_overrun = overrun_q;
  assign aux_abort   = abort_q;
  assign locked      = locked_q;
  assign esp_tx_wr   = wr_q;
  assign esp_tx_data = data_q;

  always_comb begin
    cpu_busy_d = (cpu_wr && !cpu_busy_q) ? 1'b1 : cpu_gnt_q ? 1'b0 : cpu_busy_q;
    cpu_data_d = (cpu_wr && !cpu_busy_q) ? cpu_data : cpu_data_q;
    overrun_d  = (cpu_wr && cpu_busy_q) || (overrun_q && !status_clr);
    abort_d    = timeout || (abort_q && !status_clr);
    locked_d   = gnt_aux ? !aux_last : timeout ? 1'b0 : locked_q;
    rr_d       = ((gnt_aux && aux_last) || timeout) ? 1'b1 : gnt_cpu ? 1'b0 : rr_q;
    gap_d      = (gnt_aux || gnt_cpu) ? 4'(GAP_CYCLES - 1) : (gap_q != 4'd0) ? gap_q - 4'd1 : gap_q;
    to_d       = (!locked_q || gnt_aux || timeout) ? 10'd0 : aux_valid ? to_q : to_q + 10'd1;
    wr_d       = gnt_aux || gnt_cpu;
    data_d     = gnt_aux ? aux_data : gnt_cpu ? cpu_data_q : data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_busy_q <= 1'b0;
      cpu_gnt_q  <= 1'b0;
      cpu_data_q <= 9'd0;
      overrun_q  <= 1'b0;
      abort_q    <= 1'b0;
      locked_q   <= 1'b0;
      rr_q       <= 1'b1;
      gap_q      <= 4'd0;
      to_q       <= 10'd0;
      wr_q       <= 1'b0;
      data_q     <= 9'd0;
    end else begin
      cpu_busy_q <= cpu_busy_d;
      cpu_gnt_q  <= gnt_cpu;
      cpu_data_q <= cpu_data_d;
      overrun_q  <= overrun_d;
      abort_q    <= abort_d;
      locked_q   <= locked_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
    end
  end
endmodule

// File: tb/tb_esp_tx_arbiter.sv
// tb_esp_tx_arbiter: directed-vector bench for esp_tx_arbiter (GAP_CYCLES=2, LOCK_TIMEOUT=8).
module tb_esp_tx_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_wr, aux_valid, aux_last, status_clr, esp_tx_fifo_full;
  logic [8:0] cpu_data, aux_data;
  logic       cpu_busy, cpu_overrun, aux_ready, aux_abort, locked, esp_tx_wr;
  logic [8:0] esp_tx_data;
  int         vectors = 0;
  int         miscompares = 0;

  esp_tx_arbiter #(.GAP_CYCLES(2), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_wr(cpu_wr), .cpu_data(cpu_data),
    .cpu_busy(cpu_busy), .cpu_overrun(cpu_overrun), .aux_valid(aux_valid),
    .aux_data(aux_data), .aux_last(aux_last), .aux_ready(aux_ready),
    .aux_abort(aux_abort), .status_clr(status_clr), .locked(locked),
    .esp_tx_data(esp_tx_data), .esp_tx_wr(esp_tx_wr), .esp_tx_fifo_full(esp_tx_fifo_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check outputs at the falling edge.
  task automatic step(input string tag, input logic cw, input logic [8:0] cd, input logic av,
                      input logic [8:0] ad, input logic al, input logic ff, input logic sc,
                      input logic ewr, input logic [8:0] ed, input logic erdy);
    @(posedge clk); #1;
    cpu_wr = cw; cpu_data = cd; aux_valid = av; aux_data = ad; aux_last = al;
    esp_tx_fifo_full = ff; status_clr = sc;
    @(negedge clk);
    chk({tag, " wr"}, 16'(esp_tx_wr), 16'(ewr));
    if (ewr) chk({tag, " data"}, 16'(esp_tx_data), 16'(ed));
    chk({tag, " ready"}, 16'(aux_ready), 16'(erdy));
  endtask

  task automatic idle(input string tag, input logic ewr, input logic [8:0] ed);
    step(tag, 1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, ewr, ed, 1'b0);
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    reset_n = 1'b0;
    cpu_wr = 1'b0; aux_valid = 1'b0; aux_last = 1'b0; status_clr = 1'b0;
    esp_tx_fifo_full = 1'b0; cpu_data = 9'h0; aux_data = 9'h0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [10:0] rr_wr;
    logic [10:0] rr_rdy;
    logic [8:0]  rr_dat [11];
    rr_wr  = 11'b10101010100;
    rr_rdy = 11'b00010001000;
    rr_dat = '{9'h0, 9'h0, 9'h060, 9'h0, 9'h073, 9'h0, 9'h063, 9'h0, 9'h077, 9'h0, 9'h067};
    reset_n = 1'b0;
    cpu_wr = 1'b0; cpu_data = 9'h0; aux_valid = 1'b1; aux_data = 9'h0; aux_last = 1'b1;
    status_clr = 1'b0; esp_tx_fifo_full = 1'b0;
    @(negedge clk);
    chk("rst wr", 16'(esp_tx_wr), 16'd0);
    chk("rst data", 16'(esp_tx_data), 16'd0);
    chk("rst busy", 16'(cpu_busy), 16'd0);
    chk("rst ready", 16'(aux_ready), 16'd0);
    chk("rst locked", 16'(locked), 16'd0);
    chk("rst flags", 16'({cpu_overrun, aux_abort}), 16'd0);
    do_reset();

    // CPU single byte
    step("cpu0", 1'b1, 9'h041, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0);
    chk("cpu0 busy", 16'(cpu_busy), 16'd0);
    idle("cpu1", 1'b0, 9'h0);
    chk("cpu1 busy", 16'(cpu_busy), 16'd1);
    idle("cpu2", 1'b1, 9'h041);
    chk("cpu2 busy", 16'(cpu_busy), 16'd1);
    idle("cpu3", 1'b0, 9'h0);
    chk("cpu3 busy", 16'(cpu_busy), 16'd0);

    // Overrun and sticky clear
    step("ovr0", 1'b1, 9'h011, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0);
    step("ovr1", 1'b1, 9'h022, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0);
    chk("ovr1 flag", 16'(cpu_overrun), 16'd0);
    idle("ovr2", 1'b1, 9'h011);
    chk("ovr2 flag", 16'(cpu_overrun), 16'd1);
    idle("ovr3", 1'b0, 9'h0);
    idle("ovr4", 1'b0, 9'h0);
    chk("ovr4 busy", 16'(cpu_busy), 16'd0);
    step("ovr5", 1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h0, 1'b0);
    chk("ovr5 flag", 16'(cpu_overrun), 16'd1);
    idle("ovr6", 1'b0, 9'h0);
    chk("ovr6 clr", 16'(cpu_overrun), 16'd0);
    step("ovr7", 1'b1, 9'h033, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0);
    step("ovr8", 1'b1, 9'h044, 1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h0, 1'b0);
    idle("ovr9", 1'b1, 9'h033);
    chk("ovr9 setwins", 16'(cpu_overrun), 16'd1);
    idle("ovr10", 1'b0, 9'h0);

    // Round-robin from reset with both requesters kept busy
    do_reset();
    for (int i = 0; i < 11; i++)
      step($sformatf("rr%0d", i), 1'b1, 9'(9'h060 + i), 1'(i > 0), 9'(9'h070 + i), 1'b1, 1'b0, 1'b0,
           rr_wr[i], rr_dat[i], rr_rdy[i]);
    idle("rr11", 1'b0, 9'h0);

    // Backpressure with both pending after a CPU grant: aux wins once released
    step("bp0", 1'b1, 9'h0D0, 1'b1, 9'h0E0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0, 1'b0);
    for (int i = 1; i < 50; i++)
      step("bp", 1'b0, 9'h0, 1'b1, 9'h0E0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0, 1'b0);
    chk("bp busy", 16'(cpu_busy), 16'd1);
    step("bp rel", 1'b0, 9'h0, 1'b1, 9'h0E0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 1'b1);
    idle("bp aux", 1'b1, 9'h0E0);
    idle("bp gap", 1'b0, 9'h0);
    idle("bp cpu", 1'b1, 9'h0D0);
    idle("bp idle", 1'b0, 9'h0);

    // Atomic packet with a CPU byte arriving mid-packet
    step("pk0", 1'b0, 9'h0, 1'b1, 9'h0A1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b1);
    step("pk1", 1'b1, 9'h100, 1'b1, 9'h0A2, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0A1, 1'b0);
    chk("pk1 locked", 16'(locked), 16'd1);
    step("pk2", 1'b0, 9'h0, 1'b1, 9'h0A2, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b1);
    step("pk3", 1'b0, 9'h0, 1'b1, 9'h0A3, 1'b1, 1'b0, 1'b0, 1'b1, 9'h0A2, 1'b0);
    step("pk4", 1'b0, 9'h0, 1'b1, 9'h0A3, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 1'b1);
    idle("pk5", 1'b1, 9'h0A3);
    chk("pk5 locked", 16'(locked), 16'd0);
    idle("pk6", 1'b0, 9'h0);
    idle("pk7", 1'b1, 9'h100);

    // Lock timeout after 8 stall cycles, then the waiting CPU byte goes out
    idle("to0", 1'b0, 9'h0);
    step("to1", 1'b0, 9'h0, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b1);
    step("to2", 1'b1, 9'h0BB, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h055, 1'b0);
    chk("to2 locked", 16'(locked), 16'd1);
    for (int i = 3; i < 10; i++) idle($sformatf("to%0d", i), 1'b0, 9'h0);
    chk("to9 locked", 16'(locked), 16'd1);
    chk("to9 abort", 16'(aux_abort), 16'd0);
    idle("to10", 1'b0, 9'h0);
    chk("to10 locked", 16'(locked), 16'd0);
    chk("to10 abort", 16'(aux_abort), 16'd1);
    idle("to11", 1'b1, 9'h0BB);
    step("to12", 1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h0, 1'b0);
    idle("to13", 1'b0, 9'h0);
    chk("to13 abort", 16'(aux_abort), 16'd0);

    // Asynchronous reset while locked with a CPU byte held
    step("rl0", 1'b1, 9'h0CC, 1'b1, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b1);
    idle("rl1", 1'b1, 9'h05A);
    chk("rl1 locked", 16'(locked), 16'd1);
    chk("rl1 busy", 16'(cpu_busy), 16'd1);
    #2;
    reset_n = 1'b0;
    aux_valid = 1'b1;
    #1;
    chk("rl wr", 16'(esp_tx_wr), 16'd0);
    chk("rl data", 16'(esp_tx_data), 16'd0);
    chk("rl locked", 16'(locked), 16'd0);
    chk("rl busy", 16'(cpu_busy), 16'd0);
    chk("rl ready", 16'(aux_ready), 16'd0);
    chk("rl flags", 16'({cpu_overrun, aux_abort}), 16'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    aux_valid = 1'b0;
    idle("rl2", 1'b0, 9'h0);
    idle("rl3", 1'b0, 9'h0);
    idle("rl4", 1'b0, 9'h0);
    chk("rl4 busy", 16'(cpu_busy), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
